counter_nest: RTL and testbench

Multi-level nested modulo counter that generates index tuples (e.g. band/row/column loops) for the LCMV datapath. Each level has its own run-time bound. Tuples are emitted over a valid/ready handshake. An optional triangular mode enumerates only the lower triangle of a square matrix, including the diagonal, for symmetric-matrix traversal. It replaces ad-hoc chains of single modulo counters in the sequencers.

---
 rtl/counter_nest.sv | 162 ++++++++++++++++
 tb/tb_counter_nest.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_nest.sv
// Purpose : nested multi-level modulo counter emitting index tuples, optional lower-triangle walk.
// Latency : start -> first tuple valid next cycle; one tuple per cycle while out_ready is high.
// Backpr. : idx/out_valid held stable while out_ready is low; out_valid never depends on out_ready.
//
// Ports: clk/rst_n (async active-low); start/abort/tri_en/bounds control a sequence;
//        out_valid/out_ready/idx carry tuples; wrap/last decode the current tuple;
//        busy is high while running; done pulses one cycle after a sequence completes.
module counter_nest #(
    parameter int LEVELS  = 3,
    parameter int MAX_MOD = 16,
    localparam int IW     = $clog2(MAX_MOD),
    localparam int BW     = $clog2(MAX_MOD + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 tri_en,
    input  logic [LEVELS*BW-1:0] bounds,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LEVELS*IW-1:0] idx,
    output logic [LEVELS-1:0]    wrap,
    output logic                 last,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    // Level that drives the triangular inner bound; collapses to 0 when there is
    // only one level (triangular mode is then never enabled anyway).
    localparam int L1 = (LEVELS >= 2) ? 1 : 0;

    state_t                       state_q, state_d;
    logic [LEVELS-1:0][IW-1:0]    idx_q, idx_d;
    logic [LEVELS-1:0][BW-1:0]    bnd_q, bnd_d;
    logic                         tri_q, tri_d;
    logic                         vld_q, vld_d;
    logic                         done_q, done_d;

    logic [LEVELS-1:0][BW-1:0]    eb;
    logic [LEVELS-1:0]            at_last;
    logic [LEVELS-1:0]            wrap_c;
    logic [LEVELS:0]              carry;
    logic                         fire;
    logic                         tri_in;
    logic                         any_zero;

    assign fire   = vld_q & out_ready;
    assign tri_in = tri_en & (LEVELS >= 2);

    // Effective bounds and last-value decode, from registered state only.
    always_comb begin
        for (int k = 0; k < LEVELS; k++) begin
            eb[k] = bnd_q[k];
        end
        if (tri_q) begin
            eb[0] = BW'(idx_q[L1]) + BW'(1);
        end
        for (int k = 0; k < LEVELS; k++) begin
            at_last[k] = (BW'(idx_q[k]) == (eb[k] - BW'(1)));
        end
        wrap_c[0] = vld_q & at_last[0];
        for (int k = 1; k < LEVELS; k++) begin
            wrap_c[k] = wrap_c[k-1] & at_last[k];
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        bnd_d    = bnd_q;
        tri_d    = tri_q;
        vld_d    = vld_q;
        done_d   = 1'b0;
        carry    = '0;
        carry[0] = fire;

        // In triangular mode the level-0 bound is replaced, so a zero there is harmless.
        any_zero = 1'b0;
        for (int k = 0; k < LEVELS; k++) begin
            if ((bounds[k*BW +: BW] == '0) && !((k == 0) && tri_in)) begin
                any_zero = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    bnd_d = bounds;
                    tri_d = tri_in;
                    idx_d = '0;
                    if (any_zero) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        vld_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    vld_d   = 1'b0;
                end else if (fire) begin
                    if (wrap_c[LEVELS-1]) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        vld_d   = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Ripple the increment upward through levels that are at their last value.
                        for (int k = 0; k < LEVELS; k++) begin
                            if (carry[k]) begin
                                if (at_last[k]) begin
                                    idx_d[k]   = '0;
                                    carry[k+1] = 1'b1;
                                end else begin
                                    idx_d[k] = idx_q[k] + IW'(1);
                                end
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            bnd_q   <= '0;
            tri_q   <= 1'b0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bnd_q   <= bnd_d;
            tri_q   <= tri_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    assign out_valid = vld_q;
    assign idx       = idx_q;
    assign wrap      = wrap_c;
    assign last      = wrap_c[LEVELS-1];
    assign busy      = (state_q == RUN);
    assign done      = done_q;

endmodule

// File: tb/tb_counter_nest.sv
// Purpose : bench for counter_nest; expected tuples queued at start, popped per transfer.
// Latency : checks start latency, per-cycle throughput and done timing.
// Backpr. : drives random out_ready and checks idx holds while stalled.
module tb_counter_nest;

    localparam int LV = 3;
    localparam int MM = 16;
    localparam int IW = 4;
    localparam int BW = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             tri_en = 1'b0;
    logic [LV*BW-1:0] bounds = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [LV*IW-1:0] idx;
    logic [LV-1:0]    wrap;
    logic             last;
    logic             busy;
    logic             done;

    typedef struct packed {
        logic [LV*IW-1:0] idx;
        logic [LV-1:0]    wrap;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    counter_nest #(.LEVELS(LV), .MAX_MOD(MM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .tri_en    (tri_en),
        .bounds    (bounds),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .idx       (idx),
        .wrap      (wrap),
        .last      (last),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference enumeration of the tuple sequence, built independently of the DUT.
    task automatic build(input int b2, input int b1, input int b0, input bit tri_m);
        exp_t e;
        int   eb0;
        bit   w0, w1, w2;
        exp_q.delete();
        if (b2 == 0 || b1 == 0 || (!tri_m && b0 == 0)) return;
        for (int i2 = 0; i2 < b2; i2++) begin
            for (int i1 = 0; i1 < b1; i1++) begin
                eb0 = tri_m ? i1 + 1 : b0;
                for (int i0 = 0; i0 < eb0; i0++) begin
                    w0 = (i0 == eb0 - 1);
                    w1 = w0 && (i1 == b1 - 1);
                    w2 = w1 && (i2 == b2 - 1);
                    e.idx  = {4'(i2), 4'(i1), 4'(i0)};
                    e.wrap = {w2, w1, w0};
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic run(input int b2, input int b1, input int b0, input bit tri_m,
                       input int ready_pct, input int abort_after, input bit poke_start);
        exp_t             e;
        int               n;
        int               cyc;
        bit               rdy;
        bit               stall;
        logic [LV*IW-1:0] prev_idx;
        n     = 0;
        cyc   = 0;
        stall = 1'b0;
        prev_idx = '0;
        build(b2, b1, b0, tri_m);
        @(negedge clk);
        bounds = {5'(b2), 5'(b1), 5'(b0)};
        tri_en = tri_m;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        tri_en = 1'b0;
        if (exp_q.size() == 0) begin
            check("empty_done", done, 1);
            check("empty_valid", out_valid, 0);
            check("empty_busy", busy, 0);
            @(negedge clk);
            check("empty_done_low", done, 0);
            check("empty_valid2", out_valid, 0);
            check("empty_busy2", busy, 0);
            return;
        end
        check("start_busy", busy, 1);
        check("start_idx0", idx, 0);
        while (exp_q.size() > 0 && cyc < 2000) begin
            cyc++;
            check("run_valid", out_valid, 1);
            check("run_done_low", done, 0);
            if (stall) check("stall_stable", idx, prev_idx);
            rdy       = ($urandom_range(99) < ready_pct);
            out_ready = rdy;
            start     = (poke_start && cyc == 7);
            if (rdy) begin
                e = exp_q.pop_front();
                check("idx", idx, e.idx);
                check("wrap", wrap, e.wrap);
                check("last", last, e.wrap[LV-1]);
                n++;
                if (abort_after > 0 && n == abort_after) begin
                    abort = 1'b1;
                    @(negedge clk);
                    abort     = 1'b0;
                    out_ready = 1'b0;
                    start     = 1'b0;
                    check("abort_valid", out_valid, 0);
                    check("abort_done", done, 0);
                    check("abort_busy", busy, 0);
                    check("abort_idx", idx, 0);
                    exp_q.delete();
                    @(negedge clk);
                    check("abort_done2", done, 0);
                    return;
                end
            end
            stall    = !rdy;
            prev_idx = idx;
            @(negedge clk);
        end
        start     = 1'b0;
        out_ready = 1'b0;
        if (cyc >= 2000) check("timeout", 0, 1);
        check("end_valid", out_valid, 0);
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_idx", idx, 0);
        @(negedge clk);
        check("end_done_low", done, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_idx", idx, 0);
        check("rst_wrap", wrap, 0);
        check("rst_last", last, 0);
        rst_n = 1'b1;

        run(2, 3, 4, 1'b0, 100, 0, 1'b0);   // basic count
        run(2, 3, 4, 1'b0, 50, 0, 1'b0);    // backpressure
        run(1, 4, 0, 1'b1, 100, 0, 1'b0);   // triangular (level-0 bound zero is exempt)
        run(2, 0, 4, 1'b0, 100, 0, 1'b0);   // empty sequence
        run(2, 3, 4, 1'b0, 100, 5, 1'b0);   // abort with pending transfer
        run(2, 3, 4, 1'b0, 100, 0, 1'b0);   // restart after abort
        run(1, 2, 16, 1'b0, 70, 0, 1'b1);   // max bound with start poked mid-run

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        bounds = {5'(2), 5'(3), 5'(4)};
        start  = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_idx", idx, 0);
        check("arst_wrap", wrap, 0);
        check("arst_last", last, 0);
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_valid", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
